// File: rtl/cpu_run_ctrl_pkg.sv
// Shared types and state encodings for the core run/debug controller.
package cpu_run_ctrl_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE     = 3'd0;
    localparam state_t S_RST_HOLD = 3'd1;
    localparam state_t S_RUN      = 3'd2;
    localparam state_t S_HALT     = 3'd3;
    localparam state_t S_STEP     = 3'd4;
    localparam state_t S_PASS     = 3'd5;
    localparam state_t S_FAIL     = 3'd6;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/cpu_run_ctrl.sv
// Run/debug controller: sequences core reset and clock-enable, handles halt,
// resume, single-step and a PC breakpoint, and reports pass/timeout-fail.
module cpu_run_ctrl
    import cpu_run_ctrl_pkg::*;
#(
    parameter int          RESET_CYCLES = 4,
    parameter int          TIMEOUT      = 255,
    parameter logic [31:0] PASS_VALUE   = 32'h00213d05,
    parameter logic [4:0]  CHECK_REG    = 5'd10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        halt_req,
    input  logic        resume,
    input  logic        step_req,
    input  logic        abort,
    input  logic        bp_en,
    input  logic [31:0] bp_addr,
    input  logic [31:0] pc,
    input  logic [31:0] reg_data,
    output logic        cpu_rst,
    output logic        cpu_en,
    output logic [4:0]  reg_addr,
    output logic [15:0] cycle_cnt,
    output logic [2:0]  state,
    output logic        pass,
    output logic        fail
);

    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);
    localparam logic [3:0]  RESET_LAST  = 4'(RESET_CYCLES - 1);

    state_t      state_q;
    state_t      state_nxt;
    logic [3:0]  rst_cnt;
    logic [15:0] cycle_cnt_q;
    logic        bp_skip;
    logic        pass_q;
    logic        fail_q;

    logic bp_hit;
    logic pass_hit;
    logic timeout_hit;
    logic run_rst;
    logic run_en;

    assign bp_hit      = bp_en && (pc == bp_addr) && !bp_skip;
    assign pass_hit    = (reg_data == PASS_VALUE);
    assign timeout_hit = (cycle_cnt_q == TIMEOUT_CNT);

    always_comb begin
        state_nxt = state_q;
        run_rst   = 1'b0;
        run_en    = 1'b0;
        case (state_q)
            S_IDLE: begin
                run_rst = 1'b1;
                if (start) state_nxt = S_RST_HOLD;
            end
            S_RST_HOLD: begin
                run_rst = 1'b1;
                run_en  = 1'b1;
                if (rst_cnt == RESET_LAST) state_nxt = S_RUN;
            end
            S_RUN: begin
                // Gating the enable on the hit cycle keeps the breakpoint instruction unexecuted.
                run_en = !(bp_hit || halt_req);
                if (pass_hit)                state_nxt = S_PASS;
                else if (timeout_hit)        state_nxt = S_FAIL;
                else if (bp_hit || halt_req) state_nxt = S_HALT;
            end
            S_HALT: begin
                if (step_req)    state_nxt = S_STEP;
                else if (resume) state_nxt = S_RUN;
            end
            S_STEP: begin
                run_en = 1'b1;
                if (pass_hit)         state_nxt = S_PASS;
                else if (timeout_hit) state_nxt = S_FAIL;
                else                  state_nxt = S_HALT;
            end
            S_PASS, S_FAIL: begin
                state_nxt = state_q;
            end
            default: begin
                run_rst   = 1'b1;
                state_nxt = S_IDLE;
            end
        endcase
        if (abort) state_nxt = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rst_cnt     <= 4'd0;
            cycle_cnt_q <= 16'd0;
            bp_skip     <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q <= state_nxt;
            rst_cnt <= (state_q == S_RST_HOLD) ? rst_cnt + 4'd1 : 4'd0;

            if (abort || (state_q == S_IDLE && start))
                cycle_cnt_q <= 16'd0;
            else if (run_en && !run_rst)
                cycle_cnt_q <= sat_inc16(cycle_cnt_q);

            // Skip lasts until one instruction retires, so resuming at the breakpoint PC moves on.
            if (abort)
                bp_skip <= 1'b0;
            else if (state_q == S_HALT && (step_req || resume))
                bp_skip <= 1'b1;
            else if (run_en && !run_rst)
                bp_skip <= 1'b0;

            pass_q <= (state_nxt == S_PASS);
            fail_q <= (state_nxt == S_FAIL);
        end
    end

    assign cpu_rst   = run_rst;
    assign cpu_en    = run_en;
    assign reg_addr  = CHECK_REG;
    assign cycle_cnt = cycle_cnt_q;
    assign state     = state_q;
    assign pass      = pass_q;
    assign fail      = fail_q;

endmodule
